// File: rtl/vga_frame_reader.sv
// vga_frame_reader: double-buffered 320x240 frame reader, 2x pixel/line doubled to 640x480; TEST_PATTERN_EN adds colour bars.
// Latency READ_LATENCY+2 cycles raster-in to rgb/sync-out; no backpressure, the raster free-runs and BRAM always answers.
module vga_frame_reader #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int FB_WIDTH     = 320,
  parameter int FB_HEIGHT    = 240,
  parameter int READ_LATENCY = 2,
  parameter int PIX_W        = 12,
  parameter int ADDR_W       = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              blank_in,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_bank,
  input  logic [PIX_W-1:0]  rd_data,
  input  logic              swap_req,
  output logic              swap_ack,
  input  logic              test_mode,
  output logic [PIX_W-1:0]  vga_rgb,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              blank_out
);

  localparam int PIPE  = READ_LATENCY + 2;
  localparam int ROW_W = 18;
  localparam int COL_W = 10;

  localparam logic [10:0]      H_ACT  = 11'(H_ACTIVE);
  localparam logic [9:0]       V_ACT  = 10'(V_ACTIVE);
  localparam logic [8:0]       FB_H   = 9'(FB_HEIGHT);
  localparam logic [ROW_W-1:0] ROW_INC = ROW_W'(FB_WIDTH);

  // Row base from a halved line number using shifts and adds only; used when
  // the raster jumps (reset release, non-contiguous vcount).
  function automatic logic [ROW_W-1:0] row_seed(input logic [8:0] r);
    logic [ROW_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < ROW_W; i++) begin
      if (FB_WIDTH[i]) acc = acc + (ROW_W'(r) << i);
    end
    return acc;
  endfunction

  logic [10:0]      h_q;
  logic [9:0]       v_q;
  logic [COL_W-1:0] col_q, col;
  logic [ROW_W-1:0] row_q, row;
  logic             active;

  always_comb begin
    col = col_q;
    row = row_q;
    if (hcount == 11'd0)
      col = '0;
    else if (hcount == h_q + 11'd1)
      col = hcount[0] ? col_q : col_q + COL_W'(1);
    else
      col = hcount[10:1];

    if (vcount == 10'd0)
      row = '0;
    else if (vcount == v_q)
      row = row_q;
    else if (vcount == v_q + 10'd1)
      row = vcount[0] ? row_q : row_q + ROW_INC;
    else
      row = row_seed(vcount[9:1]);

    active = (hcount < H_ACT) && (vcount < V_ACT) && (vcount[9:1] < FB_H);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q     <= '0;
      v_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      rd_addr <= '0;
    end else begin
      h_q     <= hcount;
      v_q     <= vcount;
      col_q   <= col;
      row_q   <= row;
      rd_addr <= active ? ADDR_W'(row + ROW_W'(col)) : '0;
    end
  end

  // Stage k of each delay line holds the raster point from k+1 cycles ago.
  logic [PIPE-1:0] hs_d, vs_d, bl_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_d <= '1;
      vs_d <= '1;
      bl_d <= '1;
    end else begin
      hs_d <= {hs_d[PIPE-2:0], hsync_in};
      vs_d <= {vs_d[PIPE-2:0], vsync_in};
      bl_d <= {bl_d[PIPE-2:0], blank_in};
    end
  end

  assign hsync_out = hs_d[PIPE-1];
  assign vsync_out = vs_d[PIPE-1];
  assign blank_out = bl_d[PIPE-1];

  logic [PIX_W-1:0] pix_src;

`ifdef TEST_PATTERN_EN
  localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

  function automatic logic [PIX_W-1:0] bar_colour(input logic [10:0] h);
    if      (h < BAR_W * 11'd1) return PIX_W'(12'hFFF);
    else if (h < BAR_W * 11'd2) return PIX_W'(12'hFF0);
    else if (h < BAR_W * 11'd3) return PIX_W'(12'h0FF);
    else if (h < BAR_W * 11'd4) return PIX_W'(12'h0F0);
    else if (h < BAR_W * 11'd5) return PIX_W'(12'hF0F);
    else if (h < BAR_W * 11'd6) return PIX_W'(12'hF00);
    else if (h < BAR_W * 11'd7) return PIX_W'(12'h00F);
    else                        return PIX_W'(12'h000);
  endfunction

  // {select, colour} travels alongside the BRAM read so bars share its latency.
  logic [PIPE-2:0][PIX_W:0] tp_d;

  always_ff @(posedge clk) begin
    if (reset) tp_d <= '0;
    else       tp_d <= {tp_d[PIPE-3:0], {test_mode, bar_colour(hcount)}};
  end

  always_comb begin
    pix_src = rd_data;
    if (tp_d[PIPE-2][PIX_W]) pix_src = tp_d[PIPE-2][PIX_W-1:0];
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;

  always_comb begin
    pix_src = rd_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset)               vga_rgb <= '0;
    else if (bl_d[PIPE-2])   vga_rgb <= '0;
    else                     vga_rgb <= pix_src;
  end

  // Bank swap: only on a vsync falling edge, so the displayed bank is stable for a whole frame.
  typedef enum logic [1:0] {S_IDLE, S_PEND, S_SWAP} swap_state_t;

  swap_state_t state;
  logic        vs_q;
  logic        vs_fall;

  always_ff @(posedge clk) begin
    vs_q <= vsync_in;
  end

  assign vs_fall = vs_q & ~vsync_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      rd_bank  <= 1'b0;
      swap_ack <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (swap_req) begin
            if (vs_fall) begin
              state    <= S_SWAP;
              rd_bank  <= ~rd_bank;
              swap_ack <= 1'b1;
            end else begin
              state <= S_PEND;
            end
          end
        end
        S_PEND: begin
          if (!swap_req) begin
            state <= S_IDLE;
          end else if (vs_fall) begin
            state    <= S_SWAP;
            rd_bank  <= ~rd_bank;
            swap_ack <= 1'b1;
          end
        end
        S_SWAP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader with a two-stage BRAM model returning rd_data = rd_addr[11:0].
module tb_vga_frame_reader;

  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync_in, vsync_in, blank_in;
  logic [16:0] rd_addr;
  logic        rd_bank;
  logic [11:0] rd_data;
  logic        swap_req;
  logic        swap_ack;
  logic        test_mode;
  logic [11:0] vga_rgb;
  logic        hsync_out, vsync_out, blank_out;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vga_frame_reader #(.READ_LATENCY(RL)) dut (
    .clk       (clk),
    .reset     (reset),
    .hcount    (hcount),
    .vcount    (vcount),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .blank_in  (blank_in),
    .rd_addr   (rd_addr),
    .rd_bank   (rd_bank),
    .rd_data   (rd_data),
    .swap_req  (swap_req),
    .swap_ack  (swap_ack),
    .test_mode (test_mode),
    .vga_rgb   (vga_rgb),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .blank_out (blank_out)
  );

  logic [16:0] bram_d1, bram_d2;
  always @(posedge clk) begin
    bram_d1 <= rd_addr;
    bram_d2 <= bram_d1;
  end
  assign rd_data = bram_d2[11:0];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int h, input int v, input logic bl);
    hcount   = 11'(h);
    vcount   = 10'(v);
    blank_in = bl;
  endtask

  int acks;

  initial begin
    reset = 1'b1; hcount = '0; vcount = '0;
    hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b0;
    swap_req = 1'b0; test_mode = 1'b0;

    // 1: reset state
    repeat (5) tick();
    chk("rst_rgb",   32'(vga_rgb),   32'h0);
    chk("rst_hs",    32'(hsync_out), 32'h1);
    chk("rst_vs",    32'(vsync_out), 32'h1);
    chk("rst_blank", 32'(blank_out), 32'h1);
    chk("rst_bank",  32'(rd_bank),   32'h0);
    chk("rst_ack",   32'(swap_ack),  32'h0);
    chk("rst_addr",  32'(rd_addr),   32'h0);

    // 2: address generation
    reset = 1'b0;
    for (int h = 0; h < 4; h++) begin
      drive(h, 0, 1'b0);
      tick();
      chk($sformatf("addr_h%0d", h), 32'(rd_addr), 32'(h / 2));
    end
    drive(639, 479, 1'b0); tick();
    chk("addr_max", 32'(rd_addr), 32'd76799);
    drive(640, 479, 1'b1); tick();
    chk("addr_h640", 32'(rd_addr), 32'd0);
    drive(700, 479, 1'b1); tick();
    chk("addr_h700", 32'(rd_addr), 32'd0);
    drive(5, 3, 1'b0); tick();
    chk("addr_v3h5", 32'(rd_addr), 32'd322);
    drive(6, 4, 1'b0); tick();
    chk("addr_v4h6", 32'(rd_addr), 32'd643);
    drive(0, 480, 1'b1); tick();
    chk("addr_v480", 32'(rd_addr), 32'd0);

    // 3: pixel pipeline along line v=2, hsync marker at h=10, blank at h=12
    for (int i = 0; i <= 17; i++) begin
      drive(i, 2, (i == 12));
      hsync_in = (i == 10) ? 1'b0 : 1'b1;
      tick();
      if (i == 10) chk("addr_v2h10", 32'(rd_addr), 32'd325);
      if (i == 12) begin
        chk("rgb_h9",  32'(vga_rgb),   32'd324);
        chk("hs_h9",   32'(hsync_out), 32'h1);
      end
      if (i == 13) begin
        chk("rgb_h10",   32'(vga_rgb),   32'd325);
        chk("hs_h10",    32'(hsync_out), 32'h0);
        chk("blank_h10", 32'(blank_out), 32'h0);
      end
      if (i == 15) begin
        chk("rgb_h12",   32'(vga_rgb),   32'd0);
        chk("blank_h12", 32'(blank_out), 32'h1);
      end
      if (i == 16) chk("rgb_h13", 32'(vga_rgb), 32'd326);
    end
    hsync_in = 1'b1;

    // 4: bank swap at vsync fall
    drive(100, 50, 1'b0);
    swap_req = 1'b1;
    acks = 0;
    repeat (3) begin tick(); acks += int'(swap_ack); end
    chk("pend_bank", 32'(rd_bank), 32'h0);
    chk("pend_acks", 32'(acks),    32'h0);
    vsync_in = 1'b0; tick();
    chk("swap_bank", 32'(rd_bank),  32'h1);
    chk("swap_ack",  32'(swap_ack), 32'h1);
    acks = 0;
    repeat (4) begin tick(); acks += int'(swap_ack); end
    vsync_in = 1'b1;
    repeat (3) begin tick(); acks += int'(swap_ack); end
    chk("held_acks", 32'(acks),    32'h0);
    chk("held_bank", 32'(rd_bank), 32'h1);
    swap_req = 1'b0; tick();
    // request withdrawn before the edge
    swap_req = 1'b1; tick(); tick();
    swap_req = 1'b0; tick();
    vsync_in = 1'b0; tick();
    chk("drop_bank", 32'(rd_bank),  32'h1);
    chk("drop_ack",  32'(swap_ack), 32'h0);
    vsync_in = 1'b1; tick();
    // request rising on the edge cycle itself
    swap_req = 1'b1; vsync_in = 1'b0; tick();
    chk("same_bank", 32'(rd_bank),  32'h0);
    chk("same_ack",  32'(swap_ack), 32'h1);
    swap_req = 1'b0; tick();
    chk("same_ack_end", 32'(swap_ack), 32'h0);
    vsync_in = 1'b1; tick();

    // 5: reset mid-frame with a swap pending
    drive(300, 200, 1'b0);
    swap_req = 1'b1; tick(); tick();
    reset = 1'b1; tick();
    chk("mrst_rgb",   32'(vga_rgb),   32'h0);
    chk("mrst_blank", 32'(blank_out), 32'h1);
    chk("mrst_addr",  32'(rd_addr),   32'h0);
    vsync_in = 1'b0; tick();
    swap_req = 1'b0; reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(301 + i, 200, 1'b0);
      tick();
      if (i == 0) chk("resume_addr", 32'(rd_addr), 32'd32150);
      if (i == 2) chk("resume_early", 32'(blank_out), 32'h1);
      if (i == 3) begin
        chk("resume_blank", 32'(blank_out), 32'h0);
        chk("resume_rgb",   32'(vga_rgb),   32'hD96);
      end
      if (i == 4) chk("resume_rgb2", 32'(vga_rgb), 32'hD97);
    end
    chk("mrst_bank", 32'(rd_bank), 32'h0);
    vsync_in = 1'b1; tick();

`ifdef TEST_PATTERN_EN
    // 6: colour bars
    begin
      int hs [7]       = '{0, 80, 639, 160, 0, 0, 0};
      int exp_bar [4]  = '{12'hFFF, 12'hFF0, 12'h000, 12'h0FF};
      test_mode = 1'b1;
      for (int i = 0; i < 7; i++) begin
        drive(hs[i], 10, 1'b0);
        tick();
        if (i >= 3) chk($sformatf("bar_h%0d", hs[i-3]), 32'(vga_rgb), 32'(exp_bar[i-3]));
      end
      test_mode = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
